// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Brief    : Round-robin sharing of one I2C master engine between NUM_REQ
//            requesters; one address/rw/byte transaction per grant.
//            Optional completion watchdog under macro I2C_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATAWIDTH      = 8,
  parameter int ADDRWIDTH      = 7,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GW             = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*DATAWIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATAWIDTH-1:0]          rsp_rdata,
  output logic                          rsp_nack,
  output logic                          rsp_timeout,
  output logic                          m_start,
  output logic                          m_abort,
  output logic [ADDRWIDTH-1:0]          m_addr,
  output logic                          m_rw,
  output logic [DATAWIDTH-1:0]          m_wdata,
  input  logic                          m_done,
  input  logic                          m_nack,
  input  logic [DATAWIDTH-1:0]          m_rdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          bus_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("i2c_master_arbiter: unsupported parameter set");
  end

  state_t                 r_state;
  state_t                 w_next_state;
  logic [GW-1:0]          r_last_grant;
  logic [GW-1:0]          r_grant_id;
  logic [GW-1:0]          w_idx;
  logic [GW-1:0]          w_winner;
  logic                   w_any;
  logic                   w_expired;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [DATAWIDTH-1:0]   r_rsp_rdata;
  logic                   r_rsp_nack;
  logic                   r_m_start;
  logic [ADDRWIDTH-1:0]   r_m_addr;
  logic                   r_m_rw;
  logic [DATAWIDTH-1:0]   r_m_wdata;
  logic                   r_bus_busy;

  // Search upward from the requester after the last completed owner, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = r_last_grant;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = (w_idx == GW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_any && req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int c_wdog_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wdog_w-1:0] r_wdog;
  logic                r_m_abort;
  logic                r_rsp_timeout;

  // Abort fires the cycle after the limit is reached; that cycle then exits WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog        <= '0;
      r_m_abort     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_m_abort <= 1'b0;
      case (r_state)
        S_LAUNCH: r_wdog <= '0;
        S_WAIT: begin
          if (r_m_abort) begin
            r_rsp_timeout <= 1'b1;
          end else if (m_done) begin
            r_rsp_timeout <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (r_wdog == c_wdog_w'(TIMEOUT_CYCLES - 1)) begin
              r_m_abort <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_expired   = r_m_abort;
  assign m_abort     = r_m_abort;
  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_expired   = 1'b0;
  assign m_abort     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next_state = S_LAUNCH;
      S_LAUNCH: w_next_state = S_WAIT;
      S_WAIT:   if (w_expired || m_done) w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_nack   <= 1'b0;
      r_m_start    <= 1'b0;
      r_m_addr     <= '0;
      r_m_rw       <= 1'b0;
      r_m_wdata    <= '0;
      r_bus_busy   <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_m_start   <= 1'b0;
      r_bus_busy  <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id            <= w_winner;
            r_m_addr              <= req_addr[w_winner*ADDRWIDTH +: ADDRWIDTH];
            r_m_rw                <= req_rw[w_winner];
            r_m_wdata             <= req_wdata[w_winner*DATAWIDTH +: DATAWIDTH];
            r_req_ready[w_winner] <= 1'b1;
            r_m_start             <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_expired) begin
            r_rsp_valid[r_grant_id] <= 1'b1;
            r_rsp_rdata             <= '0;
            r_rsp_nack              <= 1'b1;
          end else if (m_done) begin
            r_rsp_valid[r_grant_id] <= 1'b1;
            r_rsp_rdata             <= r_m_rw ? m_rdata : '0;
            r_rsp_nack              <= m_nack;
          end
        end
        S_RESP:  r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_nack  = r_rsp_nack;
  assign m_start   = r_m_start;
  assign m_addr    = r_m_addr;
  assign m_rw      = r_m_rw;
  assign m_wdata   = r_m_wdata;
  assign grant_id  = r_grant_id;
  assign bus_busy  = r_bus_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Brief    : Randomized self-checking bench for i2c_master_arbiter with a
//            transaction-level reference model of grants and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rw;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_nack;
  logic            rsp_timeout;
  logic            m_start;
  logic            m_abort;
  logic [AW-1:0]   m_addr;
  logic            m_rw;
  logic [DW-1:0]   m_wdata;
  logic            m_done;
  logic            m_nack;
  logic [DW-1:0]   m_rdata;
  logic [GW-1:0]   grant_id;
  logic            bus_busy;

  int n_checks = 0;
  int n_errors = 0;
  int model_last;

  i2c_master_arbiter #(
    .NUM_REQ(N), .DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT_CYCLES(TO), .GW(GW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .grant_id(grant_id), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin: first requester after the last served one, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check_value({tag, "_ready"}, 32'(req_ready), 0);
    check_value({tag, "_start"}, 32'(m_start), 0);
    check_value({tag, "_rspv"},  32'(rsp_valid), 0);
    check_value({tag, "_abort"}, 32'(m_abort), 0);
  endtask

  task automatic set_req(input int i, input int addr, input bit rw, input int wd);
    req_addr[i*AW +: AW]  = AW'(addr);
    req_rw[i]             = rw;
    req_wdata[i*DW +: DW] = DW'(wd);
  endtask

  // One full transaction starting from IDLE with req_valid already applied.
  task automatic run_txn(input int delay, input logic [N-1:0] drop_mask, input bit spur_launch,
                         input int rd_in, input int nk_in, output int g);
    logic [AW-1:0] e_addr;
    logic          e_rw;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] rd;
    logic          nk;
    g = pick(req_valid, model_last);
    if (g < 0) begin
      check_value("txn_no_request", 32'(req_valid), 1);
      return;
    end
    e_addr = req_addr[g*AW +: AW];
    e_rw   = req_rw[g];
    e_wd   = req_wdata[g*DW +: DW];
    tick();
    check_value("launch_start", 32'(m_start), 1);
    check_value("launch_ready", 32'(req_ready), 32'(1) << g);
    check_value("launch_grant", 32'(grant_id), 32'(g));
    check_value("launch_addr",  32'(m_addr), 32'(e_addr));
    check_value("launch_rw",    32'(m_rw), 32'(e_rw));
    check_value("launch_wdata", 32'(m_wdata), 32'(e_wd));
    check_value("launch_busy",  32'(bus_busy), 1);
    req_valid = req_valid & ~drop_mask;
    if (spur_launch) begin
      m_done  = 1'b1;
      m_rdata = 8'hEE;
      m_nack  = 1'b1;
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      m_done = 1'b0;
      check_quiet("wait");
      check_value("wait_busy",  32'(bus_busy), 1);
      check_value("wait_addr",  32'(m_addr), 32'(e_addr));
      check_value("wait_grant", 32'(grant_id), 32'(g));
    end
    rd      = (rd_in < 0) ? DW'($urandom_range(1, 255)) : DW'(rd_in);
    nk      = (nk_in < 0) ? 1'($urandom_range(0, 1)) : 1'(nk_in);
    m_done  = 1'b1;
    m_rdata = rd;
    m_nack  = nk;
    tick();
    m_done = 1'b0;
    check_value("resp_valid",   32'(rsp_valid), 32'(1) << g);
    check_value("resp_rdata",   32'(rsp_rdata), e_rw ? 32'(rd) : 0);
    check_value("resp_nack",    32'(rsp_nack), 32'(nk));
    check_value("resp_timeout", 32'(rsp_timeout), 0);
    check_value("resp_ready",   32'(req_ready), 0);
    model_last = g;
    tick();
    check_value("post_busy", 32'(bus_busy), 0);
    check_value("post_rspv", 32'(rsp_valid), 0);
  endtask

  initial begin
    int g;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_rw    = '0;
    req_wdata = '0;
    m_done    = 1'b0;
    m_nack    = 1'b0;
    m_rdata   = '0;
    model_last = N - 1;
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_busy",  32'(bus_busy), 0);
    check_value("rst_grant", 32'(grant_id), 0);
    check_value("rst_addr",  32'(m_addr), 0);
    check_value("rst_rdata", 32'(rsp_rdata), 0);
    check_quiet("rst");

    // Single write from requester 1, engine completes 10 cycles after start.
    set_req(1, 'h50, 1'b0, 'hA5);
    req_valid = 4'b0010;
    run_txn(10, 4'b0010, 1'b0, -1, 0, g);

    // Read with NACK from requester 2.
    set_req(2, 'h3C, 1'b1, 'h00);
    req_valid = 4'b0100;
    run_txn(3, 4'b0100, 1'b0, 'h5A, 1, g);

    // Stray m_done while idle produces nothing.
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    check_value("spur_idle_rspv", 32'(rsp_valid), 0);
    check_value("spur_idle_busy", 32'(bus_busy), 0);
    tick();
    check_quiet("spur_idle2");

    set_req(3, 'h11, 1'b0, 'h22);
    req_valid = 4'b1000;
    run_txn(2, 4'b1000, 1'b0, -1, -1, g);

    // Requester 0 served (with stray done in LAUNCH) while 3 withdraws.
    set_req(0, 'h01, 1'b1, 'h33);
    req_valid = 4'b1001;
    run_txn(4, 4'b1001, 1'b1, 'h96, 0, g);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("withdraw");
      check_value("withdraw_busy", 32'(bus_busy), 0);
    end

    // Reset during WAIT; grants restart from requester 0.
    set_req(2, 'h2A, 1'b1, 'h44);
    req_valid = 4'b0100;
    tick();
    check_value("rstw_start", 32'(m_start), 1);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("rstw_busy",  32'(bus_busy), 0);
    check_value("rstw_grant", 32'(grant_id), 0);
    check_value("rstw_addr",  32'(m_addr), 0);
    check_value("rstw_rw",    32'(m_rw), 0);
    check_value("rstw_wdata", 32'(m_wdata), 0);
    check_value("rstw_rdata", 32'(rsp_rdata), 0);
    check_value("rstw_nack",  32'(rsp_nack), 0);
    check_quiet("rstw");
    model_last = N - 1;

    // Fairness: all requesters held high across eight grants.
    for (int i = 0; i < N; i++) set_req(i, 16 + i, i[0], 'h10 * i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      run_txn($urandom_range(1, 4), 4'b0000, 1'b0, -1, -1, g);
    end
    req_valid = '0;
    tick();

    // m_done coinciding with the watchdog limit completes normally.
    set_req(1, 'h77, 1'b1, 'h00);
    req_valid = 4'b0010;
    run_txn(TO, 4'b0010, 1'b0, 'h77, 0, g);

`ifdef I2C_ARB_TIMEOUT_EN
    // Engine never completes: abort after TO WAIT cycles, then timed-out response.
    set_req(3, 'h48, 1'b1, 'h00);
    req_valid = 4'b1000;
    m_rdata   = 8'hC3;
    g         = pick(req_valid, model_last);
    tick();
    check_value("to_start", 32'(m_start), 1);
    req_valid = '0;
    for (int i = 0; i < TO; i++) begin
      tick();
      check_quiet("to_wait");
    end
    tick();
    check_value("to_abort",      32'(m_abort), 1);
    check_value("to_abort_rspv", 32'(rsp_valid), 0);
    tick();
    check_value("to_rspv",    32'(rsp_valid), 32'(1) << g);
    check_value("to_timeout", 32'(rsp_timeout), 1);
    check_value("to_nack",    32'(rsp_nack), 1);
    check_value("to_rdata",   32'(rsp_rdata), 0);
    check_value("to_abort2",  32'(m_abort), 0);
    model_last = g;
    tick();
    check_value("to_post_busy", 32'(bus_busy), 0);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 30; k++) begin
      int d;
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 127), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      end
      req_valid = N'($urandom_range(1, 15));
      d         = $urandom_range(2, 6);
      run_txn(d, N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1, -1, g);
      req_valid = '0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares the single I2C master engine between NUM_REQ on-chip requesters. It sits between the requesters and the master engine. It accepts one complete transaction at a time: a 7-bit slave address, a read/write flag and one data byte. It launches the transaction on the engine with a start pulse, waits for completion and routes the read data and ACK/NACK status back to the owning requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATAWIDTH, 8, data byte width
- ADDRWIDTH, 7, I2C slave address width
- TIMEOUT_CYCLES, 1024, completion watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN)
- GW = $clog2(NUM_REQ), derived grant index width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester transaction request
- req_addr  in  NUM_REQ*ADDRWIDTH  packed slave addresses; requester i uses [i*ADDRWIDTH +: ADDRWIDTH]
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_wdata  in  NUM_REQ*DATAWIDTH  packed write bytes
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATAWIDTH  read byte, valid with rsp_valid
- rsp_nack  out  1  slave NACK (or timeout), valid with rsp_valid
- rsp_timeout  out  1  watchdog fired, valid with rsp_valid
- m_start  out  1  one-cycle launch pulse to engine
- m_abort  out  1  one-cycle abort pulse to engine
- m_addr  out  ADDRWIDTH  address to engine, held from LAUNCH through RESP
- m_rw  out  1  direction to engine, held like m_addr
- m_wdata  out  DATAWIDTH  write byte to engine, held like m_addr
- m_done  in  1  engine completion pulse
- m_nack  in  1  engine NACK status, sampled with m_done
- m_rdata  in  DATAWIDTH  engine read byte, sampled with m_done
- grant_id  out  GW  index of current owner
- bus_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE: if any req_valid is high, pick winner g by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap. On the clock edge: latch req_addr/req_rw/req_wdata of g into m_addr/m_rw/m_wdata, set grant_id=g, go to LAUNCH.
- LAUNCH: req_ready[g]=1 and m_start=1, both for exactly one cycle. Next state is WAIT.
- WAIT: on m_done=1, capture m_rdata into rsp_rdata and m_nack into rsp_nack, then go to RESP. Otherwise stay in WAIT.
- RESP: rsp_valid[g]=1 for one cycle. Set last_grant=g. Next state is IDLE.
- rsp_rdata is forced to 0 for write transactions. Engine data is passed through only when m_rw=1.
- req_valid is sampled only in IDLE. A request dropped before capture is lost silently. A requester may drop req_valid after seeing req_ready.
- Requesters other than g are ignored until the FSM returns to IDLE. Their req_valid stays pending.
- m_done outside WAIT (including in the LAUNCH cycle) is ignored.
- m_addr/m_rw/m_wdata/grant_id do not change from LAUNCH until the next IDLE capture.

## Timing
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_timeout=0, m_start=0, m_abort=0, m_addr=0, m_rw=0, m_wdata=0, grant_id=0, bus_busy=0, watchdog=0.
- Latency: req_valid seen in IDLE at cycle T. req_ready and m_start are high at T+1. m_done at cycle D gives rsp_valid at D+1. The next grant capture is at D+2 at the earliest.
- Minimum spacing between back-to-back m_start pulses is 4 cycles.
- Reset asserted mid-transaction returns the block to reset values on the next edge. No m_abort is issued, because the engine shares rst.
- All requesters asserted continuously: grants rotate 0,1,2,3,0,… with no starvation.

## Configuration
- Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before m_done, m_abort=1 for one cycle, then RESP with rsp_timeout=1, rsp_nack=1 and rsp_rdata=0.
  - If m_done and the limit arrive in the same cycle, m_done wins (normal completion, no abort).
- Not defined: no counter is built, m_abort and rsp_timeout are tied to 0, and WAIT waits indefinitely.

## Test plan
- Single write: req_valid[1]=1, addr=7'h50, rw=0, wdata=8'hA5; engine gives m_done 10 cycles after m_start with m_nack=0. Expected: m_start one cycle after request; m_addr=7'h50, m_wdata=8'hA5; rsp_valid=4'b0010; rsp_nack=0; rsp_rdata=0.
- Read with NACK: requester 2 reads 7'h3C; engine returns m_rdata=8'h5A with m_nack=1. Expected: rsp_valid[2]; rsp_rdata=8'h5A; rsp_nack=1.
- Fairness: all four req_valid held high for 8 transactions. Expected: grant_id sequence 0,1,2,3,0,1,2,3; exactly one req_ready pulse per grant.
- Spurious done and withdrawal: pulse m_done in IDLE and in LAUNCH; drop req_valid[3] while requester 0 is being served. Expected: no rsp_valid from the stray m_done pulses; requester 3 is never granted.
- Reset mid-WAIT: assert rst for one cycle during WAIT. Expected: next cycle shows bus_busy=0, all outputs at reset values, and a following request to requester 0 is granted first.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never asserts m_done. Expected: m_abort pulse after 16 WAIT cycles; then rsp_valid with rsp_timeout=1, rsp_nack=1, rsp_rdata=0.
